map_tile_store: RTL and testbench

- Holds the 21x21 Pacman maze as 3-bit tile codes and serves them combinationally to the map display stage through its map_x/map_y/sprite_type read port.
- On reset or restart, builds the initial maze with a sequential fill FSM.
- Provides the game-logic side with a wall query, an eat-tile handshake, an orb counter and a score accumulator.
- Tile codes: 000 black, 001 big orb, 010 small orb, 011 blue wall, 100 grey ghost-house wall.

---
 rtl/map_tile_store.sv | 252 +++++++++++++++++++++++++
 tb/tb_map_tile_store.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/map_tile_store.sv
// map_tile_store: 21x21 Pacman maze tile memory.
// - Rebuilds the maze one tile per cycle after reset or restart.
// - Serves combinational display reads and wall queries.
// - Handles the eat handshake, the remaining-orb count and the saturating score.
module map_tile_store #(
    parameter int GRID      = 21,
    parameter int SMALL_PTS = 10,
    parameter int BIG_PTS   = 50
) (
    input  logic        clock_50,
    input  logic        reset,
    input  logic        restart,
    input  logic [4:0]  map_x,
    input  logic [4:0]  map_y,
    output logic [2:0]  sprite_type,
    input  logic [4:0]  query_x,
    input  logic [4:0]  query_y,
    output logic        is_wall,
    input  logic        eat_req,
    input  logic [4:0]  eat_x,
    input  logic [4:0]  eat_y,
    output logic        eat_ack,
    output logic [2:0]  eat_type,
    output logic        big_eaten,
    output logic [8:0]  orbs_left,
    output logic [15:0] score,
    output logic        ready,
    output logic        level_clear
);

    localparam int         CELLS = GRID * GRID;
    localparam logic [4:0] LIM   = 5'(GRID);
    localparam logic [4:0] LAST  = 5'(GRID - 1);
    localparam logic [4:0] NEAR  = 5'(GRID - 2);

    localparam logic [2:0] T_BLACK = 3'b000;
    localparam logic [2:0] T_BIG   = 3'b001;
    localparam logic [2:0] T_SMALL = 3'b010;
    localparam logic [2:0] T_BLUE  = 3'b011;
    localparam logic [2:0] T_GREY  = 3'b100;

    typedef enum logic [0:0] {ST_FILL = 1'b0, ST_RUN = 1'b1} state_t;

    // Initial maze layout: first matching rule wins.
    function automatic logic [2:0] fill_tile(input logic [4:0] x, input logic [4:0] y);
        logic [2:0] t;
        if (x == 5'd0 || x == LAST || y == 5'd0 || y == LAST) begin
            t = T_BLUE;
        end else if (!x[0] && !y[0]) begin
            t = T_BLUE;
        end else if (x >= 5'd8 && x <= 5'd12 && y >= 5'd9 && y <= 5'd11) begin
            t = T_GREY;
        end else if ((x == 5'd1 || x == NEAR) && (y == 5'd1 || y == NEAR)) begin
            t = T_BIG;
        end else begin
            t = T_SMALL;
        end
        return t;
    endfunction

    function automatic logic [8:0] cell_idx(input logic [4:0] x, input logic [4:0] y);
        return 9'(y) * 9'(GRID) + 9'(x);
    endfunction

    function automatic logic is_orb(input logic [2:0] t);
        return (t == T_BIG) || (t == T_SMALL);
    endfunction

    logic [2:0]  tiles_q [0:CELLS-1];

    state_t      state_q, state_d;
    logic [4:0]  fill_x_q, fill_x_d;
    logic [4:0]  fill_y_q, fill_y_d;
    logic [8:0]  orbs_left_q, orbs_left_d;
    logic [15:0] score_q, score_d;
    logic        ready_q, ready_d;
    logic        eat_ack_q, eat_ack_d;
    logic [2:0]  eat_type_q, eat_type_d;
    logic        big_eaten_q, big_eaten_d;
    logic        level_clear_q, level_clear_d;

    logic        we_s;
    logic [8:0]  wr_idx_s;
    logic [2:0]  wr_data_s;
    logic [2:0]  rd_tile_s, q_tile_s, eat_tile_s, new_tile_s;
    logic [16:0] score_sum_s;

    // Display and wall-query read ports; out-of-range cells read as blue wall.
    always_comb begin
        rd_tile_s = T_BLUE;
        q_tile_s  = T_BLUE;
        if (map_x < LIM && map_y < LIM) begin
            rd_tile_s = tiles_q[cell_idx(map_x, map_y)];
        end else begin
            rd_tile_s = T_BLUE;
        end
        if (query_x < LIM && query_y < LIM) begin
            q_tile_s = tiles_q[cell_idx(query_x, query_y)];
        end else begin
            q_tile_s = T_BLUE;
        end
        if (ready_q) begin
            sprite_type = rd_tile_s;
            is_wall     = (q_tile_s == T_BLUE) || (q_tile_s == T_GREY);
        end else begin
            sprite_type = T_BLACK;
            is_wall     = 1'b1;
        end
    end

    // Tile under the eat coordinates plus the saturating score candidate.
    always_comb begin
        eat_tile_s  = T_BLUE;
        new_tile_s  = fill_tile(fill_x_q, fill_y_q);
        if (eat_x < LIM && eat_y < LIM) begin
            eat_tile_s = tiles_q[cell_idx(eat_x, eat_y)];
        end else begin
            eat_tile_s = T_BLUE;
        end
        score_sum_s = {1'b0, score_q} +
                      ((eat_tile_s == T_BIG) ? 17'(BIG_PTS) : 17'(SMALL_PTS));
    end

    // Next-state logic for the fill sequencer and the eat handshake.
    always_comb begin
        state_d       = state_q;
        fill_x_d      = fill_x_q;
        fill_y_d      = fill_y_q;
        orbs_left_d   = orbs_left_q;
        score_d       = score_q;
        ready_d       = ready_q;
        eat_ack_d     = 1'b0;
        eat_type_d    = eat_type_q;
        big_eaten_d   = 1'b0;
        we_s          = 1'b0;
        wr_idx_s      = 9'd0;
        wr_data_s     = T_BLACK;
        case (state_q)
            ST_FILL: begin
                if (restart) begin
                    fill_x_d    = 5'd0;
                    fill_y_d    = 5'd0;
                    orbs_left_d = 9'd0;
                end else begin
                    we_s      = 1'b1;
                    wr_idx_s  = cell_idx(fill_x_q, fill_y_q);
                    wr_data_s = new_tile_s;
                    if (is_orb(new_tile_s)) begin
                        orbs_left_d = orbs_left_q + 9'd1;
                    end else begin
                        orbs_left_d = orbs_left_q;
                    end
                    if (fill_x_q == LAST) begin
                        fill_x_d = 5'd0;
                        if (fill_y_q == LAST) begin
                            fill_y_d = 5'd0;
                            state_d  = ST_RUN;
                            ready_d  = 1'b1;
                        end else begin
                            fill_y_d = fill_y_q + 5'd1;
                        end
                    end else begin
                        fill_x_d = fill_x_q + 5'd1;
                    end
                end
            end
            ST_RUN: begin
                if (restart) begin
                    state_d     = ST_FILL;
                    fill_x_d    = 5'd0;
                    fill_y_d    = 5'd0;
                    orbs_left_d = 9'd0;
                    ready_d     = 1'b0;
                end else if (eat_req) begin
                    eat_ack_d  = 1'b1;
                    eat_type_d = eat_tile_s;
                    if (is_orb(eat_tile_s)) begin
                        we_s        = 1'b1;
                        wr_idx_s    = cell_idx(eat_x, eat_y);
                        wr_data_s   = T_BLACK;
                        big_eaten_d = (eat_tile_s == T_BIG);
                        if (orbs_left_q != 9'd0) begin
                            orbs_left_d = orbs_left_q - 9'd1;
                        end else begin
                            orbs_left_d = 9'd0;
                        end
                        if (score_sum_s[16]) begin
                            score_d = 16'hFFFF;
                        end else begin
                            score_d = score_sum_s[15:0];
                        end
                    end else begin
                        we_s = 1'b0;
                    end
                end else begin
                    eat_ack_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_FILL;
                fill_x_d    = 5'd0;
                fill_y_d    = 5'd0;
                orbs_left_d = 9'd0;
                ready_d     = 1'b0;
            end
        endcase
        level_clear_d = ready_d && (orbs_left_d == 9'd0);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q       <= ST_FILL;
            fill_x_q      <= 5'd0;
            fill_y_q      <= 5'd0;
            orbs_left_q   <= 9'd0;
            score_q       <= 16'd0;
            ready_q       <= 1'b0;
            eat_ack_q     <= 1'b0;
            eat_type_q    <= T_BLACK;
            big_eaten_q   <= 1'b0;
            level_clear_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_x_q      <= fill_x_d;
            fill_y_q      <= fill_y_d;
            orbs_left_q   <= orbs_left_d;
            score_q       <= score_d;
            ready_q       <= ready_d;
            eat_ack_q     <= eat_ack_d;
            eat_type_q    <= eat_type_d;
            big_eaten_q   <= big_eaten_d;
            level_clear_q <= level_clear_d;
        end
    end

    // Single tile write port shared by the fill sequencer and eats.
    always_ff @(posedge clock_50) begin
        if (!reset && we_s) begin
            tiles_q[wr_idx_s] <= wr_data_s;
        end
    end

    assign eat_ack     = eat_ack_q;
    assign eat_type    = eat_type_q;
    assign big_eaten   = big_eaten_q;
    assign orbs_left   = orbs_left_q;
    assign score       = score_q;
    assign ready       = ready_q;
    assign level_clear = level_clear_q;

endmodule

// File: tb/tb_map_tile_store.sv
// Self-checking bench for map_tile_store with a maze-level reference model.
module tb_map_tile_store;

    logic        clock_50 = 1'b0;
    logic        reset, restart, eat_req;
    logic [4:0]  map_x, map_y, query_x, query_y, eat_x, eat_y;
    logic [2:0]  sprite_type, eat_type;
    logic        is_wall, eat_ack, big_eaten, ready, level_clear;
    logic [8:0]  orbs_left;
    logic [15:0] score;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_tile [441];
    int m_score, m_orbs, m_cnt, m_ack, m_type, m_big;
    bit m_ready;

    map_tile_store dut (
        .clock_50(clock_50), .reset(reset), .restart(restart),
        .map_x(map_x), .map_y(map_y), .sprite_type(sprite_type),
        .query_x(query_x), .query_y(query_y), .is_wall(is_wall),
        .eat_req(eat_req), .eat_x(eat_x), .eat_y(eat_y),
        .eat_ack(eat_ack), .eat_type(eat_type), .big_eaten(big_eaten),
        .orbs_left(orbs_left), .score(score), .ready(ready),
        .level_clear(level_clear)
    );

    always #5 clock_50 = ~clock_50;

    function automatic int rule(int x, int y);
        if (x == 0 || x == 20 || y == 0 || y == 20) return 3;
        if (x % 2 == 0 && y % 2 == 0) return 3;
        if (x >= 8 && x <= 12 && y >= 9 && y <= 11) return 4;
        if ((x == 1 || x == 19) && (y == 1 || y == 19)) return 1;
        return 2;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model, compare registered outputs.
    task automatic tick(input bit rst, input bit rs, input bit rq, input int x, input int y);
        int t;
        reset = rst; restart = rs; eat_req = rq;
        eat_x = 5'(x); eat_y = 5'(y);
        m_ack = 0; m_big = 0;
        if (rst) begin
            m_cnt = 0; m_ready = 0; m_orbs = 0; m_score = 0; m_type = 0;
        end else if (!m_ready) begin
            if (rs) begin
                m_cnt = 0; m_orbs = 0;
            end else begin
                m_tile[m_cnt] = rule(m_cnt % 21, m_cnt / 21);
                if (m_tile[m_cnt] == 1 || m_tile[m_cnt] == 2) m_orbs++;
                m_cnt++;
                if (m_cnt == 441) m_ready = 1;
            end
        end else if (rs) begin
            m_ready = 0; m_cnt = 0; m_orbs = 0;
        end else if (rq) begin
            m_ack = 1;
            if (x >= 21 || y >= 21) begin
                m_type = 3;
            end else begin
                t = m_tile[y * 21 + x];
                m_type = t;
                if (t == 1 || t == 2) begin
                    m_tile[y * 21 + x] = 0;
                    if (m_orbs > 0) m_orbs--;
                    m_score += (t == 1) ? 50 : 10;
                    if (m_score > 65535) m_score = 65535;
                    m_big = (t == 1);
                end
            end
        end
        @(posedge clock_50);
        #1;
        chk("eat_ack", eat_ack, m_ack);
        chk("eat_type", eat_type, m_type);
        chk("big_eaten", big_eaten, m_big);
        chk("score", score, m_score);
        chk("orbs_left", orbs_left, m_orbs);
        chk("ready", ready, m_ready);
        chk("level_clear", level_clear, (m_ready && m_orbs == 0) ? 1 : 0);
    endtask

    // Read port check against model (and a constant when want >= 0), then one idle clock.
    task automatic rd(input int x, input int y, input int want);
        int es, ew;
        map_x = 5'(x); map_y = 5'(y); query_x = 5'(x); query_y = 5'(y);
        @(negedge clock_50);
        if (!m_ready) begin
            es = 0; ew = 1;
        end else if (x >= 21 || y >= 21) begin
            es = 3; ew = 1;
        end else begin
            es = m_tile[y * 21 + x];
            ew = (es == 3 || es == 4) ? 1 : 0;
        end
        chk("sprite_type", sprite_type, es);
        chk("is_wall", is_wall, ew);
        if (want >= 0) begin
            chk("sprite_const", sprite_type, want);
            chk("wall_const", is_wall, (want == 3 || want == 4) ? 1 : 0);
        end
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic eat_all();
        for (int i = 0; i < 441; i++) begin
            if (m_tile[i] == 1 || m_tile[i] == 2) tick(0, 0, 1, i % 21, i / 21);
        end
    endtask

    initial begin
        reset = 1'b1; restart = 1'b0; eat_req = 1'b0;
        eat_x = 5'd0; eat_y = 5'd0;
        map_x = 5'd0; map_y = 5'd0; query_x = 5'd0; query_y = 5'd0;
        m_score = 0; m_orbs = 0; m_cnt = 0; m_ready = 0; m_type = 0;
        m_ack = 0; m_big = 0;
        for (int i = 0; i < 441; i++) m_tile[i] = 0;

        // Reset state
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        chk("rst_score", score, 0);
        chk("rst_eat_type", eat_type, 0);
        map_x = 5'd3; map_y = 5'd3; query_x = 5'd3; query_y = 5'd3;
        @(negedge clock_50);
        chk("rst_sprite", sprite_type, 0);
        chk("rst_wall", is_wall, 1);

        // Fill latency boundary
        repeat (440) tick(0, 0, 0, 0, 0);
        chk("ready_at_440", ready, 0);
        tick(0, 0, 0, 0, 0);
        chk("ready_at_441", ready, 1);
        chk("orbs_full", orbs_left, 268);

        // Directed reads
        rd(0, 5, 3); rd(2, 2, 3); rd(1, 1, 1); rd(1, 2, 2); rd(9, 9, 4); rd(25, 3, 3);

        // Small orb, then repeat on the same tile
        tick(0, 0, 1, 1, 3);
        chk("eat13_ack", eat_ack, 1);
        chk("eat13_type", eat_type, 2);
        chk("eat13_score", score, 10);
        chk("eat13_orbs", orbs_left, 267);
        tick(0, 0, 1, 1, 3);
        chk("eat13_rep_type", eat_type, 0);
        chk("eat13_rep_score", score, 10);
        rd(1, 3, 0);

        // Big orb and a wall eat
        tick(0, 0, 1, 19, 19);
        chk("big_type", eat_type, 1);
        chk("big_pulse", big_eaten, 1);
        chk("big_score", score, 60);
        tick(0, 0, 0, 0, 0);
        chk("big_pulse_end", big_eaten, 0);
        chk("ack_end", eat_ack, 0);
        tick(0, 0, 1, 0, 0);
        chk("wall_type", eat_type, 3);
        chk("wall_score", score, 60);
        rd(0, 0, 3);

        // Random eats and reads
        repeat (60) begin
            int rx, ry;
            rx = $urandom_range(0, 23);
            ry = $urandom_range(0, 23);
            if ($urandom_range(0, 1) == 1) tick(0, 0, 1, rx, ry);
            else rd(rx, ry, -1);
        end

        // Clear the level back-to-back
        chk("lc_before", level_clear, 0);
        eat_all();
        chk("clear_orbs", orbs_left, 0);
        chk("clear_lc", level_clear, 1);
        chk("clear_score", score, 2840);

        // Score saturation over many levels
        for (int l = 0; l < 23; l++) begin
            tick(0, 1, 0, 0, 0);
            repeat (441) tick(0, 0, 0, 0, 0);
            eat_all();
        end
        chk("sat_score", score, 65535);
        tick(0, 1, 0, 0, 0);
        repeat (441) tick(0, 0, 0, 0, 0);
        chk("restart_score", score, 65535);
        chk("restart_orbs", orbs_left, 268);

        // Reset in mid-fill
        tick(0, 1, 0, 0, 0);
        repeat (200) tick(0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        chk("abort_score", score, 0);
        chk("abort_ready", ready, 0);
        repeat (440) tick(0, 0, 0, 0, 0);
        chk("refill_440", ready, 0);
        tick(0, 0, 0, 0, 0);
        chk("refill_441", ready, 1);

        // Reset together with an eat request
        tick(1, 0, 1, 1, 1);
        chk("rsteat_ack", eat_ack, 0);
        chk("rsteat_score", score, 0);
        repeat (441) tick(0, 0, 0, 0, 0);
        tick(0, 0, 1, 1, 1);
        chk("post_big_type", eat_type, 1);
        chk("post_big_score", score, 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
